// File: rtl/ir_pkg.sv
// ir_pkg: protocol constants, register map and decoder states shared with the gun
package ir_pkg;
    localparam int IR_CODE_W      = 11;
    localparam int IR_START_UNITS = 6;
    localparam int IR_SLOT_UNITS  = 5;
    localparam int IR_FRAME_UNITS = 70;
    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    typedef enum logic [2:0] {S_IDLE, S_START, S_SPACE, S_BIT, S_COMMIT} ir_state_t;
endpackage

// File: rtl/ir_receiver_if.sv
// ir_receiver_if: APB3 bus between the processor and the IR receiver
interface ir_receiver_if;
    logic        PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY, PSLVERR);
    modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/ir_input_filter.sv
// ir_input_filter: synchronizes the sensor output and rejects glitches shorter than GLITCH_CYCLES
module ir_input_filter #(
    parameter int GLITCH_CYCLES = 64
) (
    input  logic PCLK,
    input  logic PRESETN,
    input  logic ir_recv,
    output logic mark,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(GLITCH_CYCLES + 1);
    logic s1, s2, flip;
    logic [CW-1:0] cnt;
    // raw level high while mark is set (or low while clear) means the input disagrees
    assign flip = (s2 == mark) && (cnt == CW'(GLITCH_CYCLES - 1));
    // synchronizer idles high (no carrier); mark follows only after a full run of disagreeing samples
    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            cnt  <= '0;
            mark <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= ir_recv;
            s2   <= s1;
            cnt  <= (s2 == mark && !flip) ? cnt + 1'b1 : '0;
            mark <= flip ? ~mark : mark;
            rise <= flip && !mark;
            fall <= flip && mark;
        end
endmodule

// File: rtl/ir_receiver.sv
// ir_receiver: APB3 slave decoding pulse-width IR shooter frames into an 11-bit code
module ir_receiver
    import ir_pkg::*;
#(
    parameter int UNIT_CYCLES   = 17880,
    parameter int GLITCH_CYCLES = 64,
    parameter int HOLDOFF_UNITS = 80
) (
    input  logic         PCLK,
    input  logic         PRESETN,
    ir_receiver_if.slave apb,
    input  logic         ir_recv,
    output logic         ir_irq
);
    localparam logic [19:0] W_MAX     = 20'(8 * UNIT_CYCLES);
    localparam logic [19:0] START_MIN = 20'((IR_START_UNITS - 1) * UNIT_CYCLES);
    localparam logic [19:0] START_MAX = 20'((IR_START_UNITS + 1) * UNIT_CYCLES);
    localparam logic [19:0] SPACE_MAX = 20'(4 * UNIT_CYCLES);
    localparam logic [19:0] BIT_LO    = 20'(3 * UNIT_CYCLES / 2);
    localparam logic [19:0] BIT_MID   = 20'(5 * UNIT_CYCLES / 2);
    localparam logic [19:0] BIT_HI    = 20'(7 * UNIT_CYCLES / 2);
    localparam logic [23:0] HOLD      = 24'(HOLDOFF_UNITS * UNIT_CYCLES);

    ir_state_t state, state_nx;
    logic mark, rise, fall, err, shift, commit, dup, accept, wr, rd_data;
    logic valid, overrun, en, irq_en, unused_pwdata;
    logic [19:0] width;
    logic [3:0]  bitcnt;
    logic [IR_CODE_W-1:0] shreg, code, last_code;
    logic [23:0] holdoff;
    logic [7:0]  errcnt;

    ir_input_filter #(.GLITCH_CYCLES(GLITCH_CYCLES)) u_filter (
        .PCLK(PCLK), .PRESETN(PRESETN), .ir_recv(ir_recv), .mark(mark), .rise(rise), .fall(fall)
    );

    assign wr            = apb.PSEL && apb.PENABLE && apb.PWRITE;
    assign rd_data       = apb.PSEL && apb.PENABLE && !apb.PWRITE && apb.PADDR == ADDR_DATA;
    assign commit        = state == S_COMMIT && shreg != '0;
    assign dup           = shreg == last_code && holdoff < HOLD;
    assign accept        = commit && !dup;
    assign ir_irq        = valid && irq_en;
    assign apb.PREADY    = 1'b1;
    assign apb.PSLVERR   = 1'b0;
    assign unused_pwdata = ^apb.PWDATA[31:2];
    assign apb.PRDATA    = !(apb.PSEL && !apb.PWRITE)   ? '0 :
                           apb.PADDR == ADDR_DATA   ? {valid, overrun, {(30 - IR_CODE_W){1'b0}}, code} :
                           apb.PADDR == ADDR_STATUS ? {24'd0, errcnt} :
                           apb.PADDR == ADDR_CTRL   ? {30'd0, irq_en, en} : '0;

    // frame parser: widths are judged at the closing edge; stale marks after errors wait for a fresh rise
    always_comb begin
        state_nx = state;
        err      = 1'b0;
        shift    = 1'b0;
        case (state)
            S_IDLE:   if (rise) state_nx = S_START;
            S_START:  if (fall) begin
                          err      = !(width >= START_MIN && width <= START_MAX);
                          state_nx = err ? S_IDLE : S_SPACE;
                      end
            S_SPACE:  if (rise) state_nx = S_BIT;
                      else if (!mark && width >= SPACE_MAX) begin
                          err      = 1'b1;
                          state_nx = S_IDLE;
                      end
            S_BIT:    if (fall) begin
                          err      = !(width >= BIT_LO && width < BIT_HI);
                          shift    = !err;
                          state_nx = err ? S_IDLE : (bitcnt == 4'(IR_CODE_W - 1) ? S_COMMIT : S_SPACE);
                      end
            default:  state_nx = S_IDLE;
        endcase
        if (!en) begin
            state_nx = S_IDLE;
            err      = 1'b0;
            shift    = 1'b0;
        end
    end

    // decoder state register
    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) state <= S_IDLE;
        else state <= state_nx;

    // width holds the length so far of the current mark or space; bits shift in MSB first
    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            width  <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else begin
            width  <= (rise || fall) ? 20'd1 : (width == W_MAX ? width : width + 20'd1);
            bitcnt <= (state == S_START) ? 4'd0 : bitcnt + 4'(shift);
            if (shift) shreg <= {shreg[IR_CODE_W-2:0], width >= BIT_MID};
        end

    // software-visible registers; a commit outranks a same-cycle clear-on-read
    always_ff @(posedge PCLK or negedge PRESETN)
        if (!PRESETN) begin
            holdoff   <= '0;
            code      <= '0;
            last_code <= '0;
            valid     <= 1'b0;
            overrun   <= 1'b0;
            errcnt    <= '0;
            en        <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            holdoff <= commit ? '0 : (holdoff == '1 ? holdoff : holdoff + 24'd1);
            if (accept) begin
                code      <= shreg;
                last_code <= shreg;
                valid     <= 1'b1;
                overrun   <= !rd_data && (overrun || valid);
            end else if (rd_data) begin
                valid   <= 1'b0;
                overrun <= 1'b0;
            end
            errcnt <= (wr && apb.PADDR == ADDR_STATUS) ? '0 : errcnt + 8'(err && errcnt != 8'hFF);
            if (wr && apb.PADDR == ADDR_CTRL) begin
                en     <= apb.PWDATA[0];
                irq_en <= apb.PWDATA[1];
            end
        end
endmodule

// File: tb/tb_ir_receiver.sv
// tb_ir_receiver: randomized self-checking bench for the IR frame decoder
module tb_ir_receiver;
    localparam int U  = 100;
    localparam int G  = 4;
    localparam int HU = 80;
    localparam logic [7:0] A_DATA = 8'h00, A_STATUS = 8'h04, A_CTRL = 8'h08;

    logic PCLK = 1'b0;
    logic PRESETN = 1'b0;
    logic ir_recv = 1'b1;
    logic ir_irq;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int t_last = 0;

    logic m_valid, m_ovr, m_irq_en;
    logic [10:0] m_code, m_last;
    int m_hold_t, m_err;

    ir_receiver_if apb();

    ir_receiver #(.UNIT_CYCLES(U), .GLITCH_CYCLES(G), .HOLDOFF_UNITS(HU)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .apb(apb), .ir_recv(ir_recv), .ir_irq(ir_irq)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc++;

    initial begin
        #1500000;
        $display("FAIL watchdog: cycle %0d reached, limit 150000", cyc);
        $fatal(1);
    end

    function automatic void model_reset();
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_irq_en = 1'b0;
        m_code   = '0;
        m_last   = '0;
        m_hold_t = cyc;
        m_err    = 0;
    endfunction

    // decoded frame at time t: idle code dropped, fresh repeats dropped and restart the window
    function automatic void model_commit(input logic [10:0] c, input int t);
        if (c == 11'd0) return;
        if (c == m_last && t - m_hold_t < HU * U) begin
            m_hold_t = t;
            return;
        end
        m_ovr    = m_ovr | m_valid;
        m_valid  = 1'b1;
        m_code   = c;
        m_last   = c;
        m_hold_t = t;
    endfunction

    function automatic logic [31:0] model_read();
        logic [31:0] r;
        r = {m_valid, m_ovr, 19'd0, m_code};
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        return r;
    endfunction

    task automatic drive(input logic lvl, input int n);
        ir_recv = lvl;
        repeat (n) @(negedge PCLK);
    endtask

    task automatic space(input int n, input bit glitch);
        int p;
        if (glitch) begin
            p = int'($urandom_range(n - 10, 8));
            drive(1'b1, p);
            drive(1'b0, 3);
            drive(1'b1, n - p - 3);
        end else drive(1'b1, n);
    endtask

    task automatic send_bits(input logic [10:0] c, input int nbits, input bit glitch);
        drive(1'b0, 6 * U);
        space(2 * U, glitch);
        for (int i = 10; i > 10 - nbits; i--) begin
            drive(1'b0, c[i] ? 3 * U : 2 * U);
            t_last = cyc;
            space(c[i] ? 2 * U : 3 * U, glitch);
        end
    endtask

    task automatic send_frame(input logic [10:0] c, input int gap_u, input bit glitch);
        send_bits(c, 11, glitch);
        drive(1'b1, gap_u * U);
        model_commit(c, t_last);
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        apb.PSEL = 1'b1; apb.PWRITE = 1'b1; apb.PADDR = a; apb.PWDATA = d; apb.PENABLE = 1'b0;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        apb.PSEL = 1'b1; apb.PWRITE = 1'b0; apb.PADDR = a; apb.PENABLE = 1'b0;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        #1 d = apb.PRDATA;
        @(negedge PCLK);
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d, e;
        repeat (3) @(negedge PCLK);
        checks++; if (ir_irq !== 1'b0) begin errors++; $display("FAIL rst_irq_in_reset: got %b want 0", ir_irq); end
        PRESETN = 1'b1;
        model_reset();
        @(negedge PCLK);
        checks++; if (apb.PREADY !== 1'b1) begin errors++; $display("FAIL pready: got %b want 1", apb.PREADY); end
        checks++; if (apb.PSLVERR !== 1'b0) begin errors++; $display("FAIL pslverr: got %b want 0", apb.PSLVERR); end
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL rst_data: got %h want %h", d, e); end
        apb_read(A_STATUS, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_status: got %h want 0", d); end
        apb_read(A_CTRL, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL rst_ctrl: got %h want 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d, e;
        apb_write(A_CTRL, 32'd3);
        m_irq_en = 1'b1;
        apb_read(A_CTRL, d);
        checks++; if (d !== 32'd3) begin errors++; $display("FAIL ctrl_rw: got %h want 3", d); end
        send_frame(11'h5A3, 2, 1'b0);
        checks++; if (ir_irq !== (m_valid & m_irq_en)) begin errors++; $display("FAIL basic_irq: got %b want %b", ir_irq, m_valid & m_irq_en); end
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL basic_data: got %h want %h", d, e); end
        checks++; if (ir_irq !== (m_valid & m_irq_en)) begin errors++; $display("FAIL basic_irq_clear: got %b want %b", ir_irq, m_valid & m_irq_en); end
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL basic_reread: got %h want %h", d, e); end
    endtask

    task automatic test_overrun();
        logic [31:0] d, e;
        send_frame(11'h123, 2, 1'b0);
        send_frame(11'h456, 2, 1'b0);
        checks++; if (ir_irq !== (m_valid & m_irq_en)) begin errors++; $display("FAIL ovr_irq: got %b want %b", ir_irq, m_valid & m_irq_en); end
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL ovr_data: got %h want %h", d, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, e;
        for (int k = 0; k < 5; k++) send_frame(11'h123, (k == 4) ? 2 : 7, 1'b0);
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL repeat_data: got %h want %h", d, e); end
        apb_read(A_STATUS, d);
        checks++; if (d !== 32'(m_err)) begin errors++; $display("FAIL repeat_errcnt: got %h want %h", d, m_err); end
    endtask

    task automatic test_errors();
        logic [31:0] d, e;
        logic [10:0] c;
        c = 11'($urandom);
        drive(1'b0, 4 * U);
        drive(1'b1, 6 * U);
        m_err++;
        send_bits(c, 2, 1'b0);
        drive(1'b0, 4 * U);
        drive(1'b1, 6 * U);
        m_err++;
        apb_read(A_STATUS, d);
        checks++; if (d !== 32'(m_err)) begin errors++; $display("FAIL err_count: got %h want %h", d, m_err); end
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL err_no_valid: got %h want %h", d, e); end
        send_frame(11'h7FF, 2, 1'b0);
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL err_recover: got %h want %h", d, e); end
        apb_write(A_STATUS, 32'd0);
        m_err = 0;
        apb_read(A_STATUS, d);
        checks++; if (d !== 32'(m_err)) begin errors++; $display("FAIL err_clear: got %h want %h", d, m_err); end
    endtask

    task automatic test_glitch();
        logic [31:0] d, e;
        send_frame(11'h001, 2, 1'b1);
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL glitch_data: got %h want %h", d, e); end
        send_frame(11'h000, 2, 1'b1);
        checks++; if (ir_irq !== (m_valid & m_irq_en)) begin errors++; $display("FAIL zero_irq: got %b want %b", ir_irq, m_valid & m_irq_en); end
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL zero_data: got %h want %h", d, e); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        logic [10:0] c;
        c = 11'($urandom);
        send_bits(c, 5, 1'b0);
        drive(1'b0, U);
        PRESETN = 1'b0;
        ir_recv = 1'b1;
        repeat (4) @(negedge PCLK);
        checks++; if (ir_irq !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b want 0", ir_irq); end
        PRESETN = 1'b1;
        model_reset();
        @(negedge PCLK);
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL mid_rst_data: got %h want %h", d, e); end
        apb_read(A_STATUS, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_rst_status: got %h want 0", d); end
        apb_read(A_CTRL, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL mid_rst_ctrl: got %h want 0", d); end
        apb_write(A_CTRL, 32'd3);
        m_irq_en = 1'b1;
        send_frame(11'h2AA, 2, 1'b0);
        e = model_read();
        apb_read(A_DATA, d);
        checks++; if (d !== e) begin errors++; $display("FAIL mid_rst_frame: got %h want %h", d, e); end
    endtask

    initial begin
        apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
        model_reset();
        test_reset();
        test_basic();
        test_overrun();
        test_back_to_back();
        test_errors();
        test_glitch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ir_receiver.md
# ir_receiver

APB3 slave that decodes frames from the demodulated IR sensor on the target vest and presents the received 11-bit shooter code to the processor. It is the receive end of the gun's pulse-width protocol: a 6-unit start mark, a 2-unit space, then 11 bit slots MSB first, each slot 5 units long (bit 0: 2-unit mark; bit 1: 3-unit mark). One unit is `UNIT_CYCLES` PCLK cycles. Frames repeat every 70 units while the gun is firing. The block filters the input, measures mark and space widths, assembles the code, suppresses repeats, and raises an interrupt.

## Interface
- `UNIT_CYCLES`, 17880: PCLK cycles per protocol unit.
- `GLITCH_CYCLES`, 64: cycles the synchronized input must be stable before the filtered level changes.
- `HOLDOFF_UNITS`, 80: window in units during which an identical code is suppressed.
- `PCLK`  in  1  clock.
- `PRESETN`  in  1  reset; asynchronous, active-low.
- `PSEL`, `PENABLE`, `PWRITE`  in  1  APB control.
- `PADDR`  in  8  register address.
- `PWDATA`  in  32  write data.
- `PRDATA`  out  32  read data.
- `PREADY`  out  1  tied to 1.
- `PSLVERR`  out  1  tied to 0.
- `ir_recv`  in  1  demodulated sensor output; low means mark (carrier present). Asynchronous to PCLK.
- `ir_irq`  out  1  level interrupt: `VALID & CTRL.IRQ_EN`.

## Operation
- Registers (write = `PSEL&PENABLE&PWRITE`, read access = `PSEL&PENABLE&!PWRITE`):
  - 0x00 DATA (read-only): bit 31 VALID, bit 30 OVERRUN, bits 10:0 CODE. A read access clears VALID and OVERRUN.
  - 0x04 STATUS: bits 7:0 ERRCNT (saturates at 255). Any write clears it.
  - 0x08 CTRL (read/write): bit 0 EN, bit 1 IRQ_EN.
  - Any other address reads 0.
- `PRDATA` is combinational from `PADDR` whenever `PSEL & !PWRITE`, and 0 otherwise.
- Input path: 2-flop synchronizer, then a glitch filter. The filtered `mark` changes only after `GLITCH_CYCLES` consecutive equal samples. All widths are measured on `mark`.
- Width counter: 20 bits. It resets on every `mark` edge and saturates at 8·U (U = `UNIT_CYCLES`).
- FSM states and transitions:
  - IDLE: wait for a rising edge of `mark`. A mark already present when EN rises is ignored until it ends.
  - START: measure the mark. On mark end, a width in [5U, 7U] goes to SPACE with bitcnt=0. Any other width is an error.
  - SPACE: wait for the next mark. A space reaching 4U is an error.
  - BIT: measure the mark. On mark end, a width in [1.5U, 2.5U) shifts in 0 and a width in [2.5U, 3.5U) shifts in 1; any other width is an error. After the 11th bit go to COMMIT, otherwise go to SPACE.
  - COMMIT: one cycle, then IDLE.
- Error handling: ERRCNT increments and the FSM returns to IDLE. A mark that is still low when the error is detected must end before a new start is accepted.
- Commit rules, in priority order:
  - CODE 0 is discarded (idle frame).
  - A code equal to the last accepted code, with fewer than `HOLDOFF_UNITS`·U cycles since that acceptance, is discarded and restarts the holdoff timer.
  - Otherwise the code is accepted: CODE is loaded, VALID is set, and the holdoff timer and last-code register are reloaded. If VALID was already 1, OVERRUN is set as well.
- Read and commit in the same cycle: the commit wins. VALID stays 1 with the new CODE, and OVERRUN is not set.
- Clearing EN: the FSM goes to IDLE and the partial frame is dropped. Registers are unchanged.

## Timing
- Reset: all registers, PRDATA, ir_irq, ERRCNT, CTRL and the holdoff timer are 0; the last code is 0; the FSM is in IDLE.
- Input-to-`mark` latency: 2 + `GLITCH_CYCLES` cycles, equal on both edges, so measured widths are unaffected.
- VALID and ir_irq rise 1 cycle after COMMIT, i.e. 4 + `GLITCH_CYCLES` cycles after `ir_recv` rises at the end of the last bit mark.
- APB accesses have zero wait states. Clear-on-read takes effect on the cycle after the access.
- Holdoff timer: 24 bits, counts up and saturates.

## Structure
- Package `ir_pkg`, shared with the gun:
  - `IR_CODE_W` = 11, `IR_START_UNITS` = 6, `IR_SLOT_UNITS` = 5, `IR_FRAME_UNITS` = 70.
  - Register offsets.
  - FSM state enum.
- Sub-module `ir_input_filter`: synchronizer plus glitch filter, outputs `mark` and a one-cycle `rise`/`fall` pulse.

## Test plan
Simulation uses `UNIT_CYCLES`=100, `GLITCH_CYCLES`=4, `HOLDOFF_UNITS`=80.
- EN=1, IRQ_EN=1, send code 0x5A3 -> DATA reads 0x800005A3 and ir_irq rises; after the read DATA reads 0x000005A3 and ir_irq=0.
- Send 0x123 five times at 70-unit spacing -> exactly one accept; ERRCNT stays 0.
- Send 0x123, then 0x456 without reading -> DATA reads 0xC0000456.
- Start mark of 4U, then a bit mark of 4U inside a valid frame -> ERRCNT=2 and VALID=0; a following valid frame 0x7FF is accepted.
- Single 3-cycle low glitches on `ir_recv` during spaces -> frame 0x001 decodes correctly; an all-zero frame leaves VALID=0.
- Assert PRESETN low mid-frame at bit 6, release, send 0x2AA -> every register is 0 after reset; 0x2AA is accepted once EN is set again.
